// File: rtl/pc_fetch_unit.sv
// Fetch-side datapath: program counter, instruction register, ALUOut register
// and next-PC resolution for BEQ/BNE, J/JAL and JR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_we,
  input  logic             ir_we,
  input  logic [1:0]       pcsrc,
  input  logic             ben,
  input  logic             beqbne,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      reg_a,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      instruction,
  output logic [31:0]      alu_out,
  output logic [31:0]      link_addr,
  output logic             branch_taken,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_alu_out;
  logic             r_misalign;
  logic [CNT_W-1:0] r_retired;

  logic             w_branch_taken;
  logic [31:0]      w_npc;
  logic             w_pc_write;
  logic [31:0]      w_pc_wdata;
  logic             w_wdata_misaligned;

  assign w_branch_taken = ben & (alu_zero ^ beqbne);

  // The J target deliberately uses the IR contents from before this edge,
  // so a simultaneous IR load does not affect the jump being resolved.
  always_comb begin
    w_npc = alu_result;
    case (pcsrc)
      2'd0: w_npc = r_alu_out;
      2'd1: w_npc = {r_pc[31:28], r_instr[25:0], 2'b00};
      2'd2: w_npc = alu_result;
      2'd3: w_npc = reg_a;
      default: w_npc = alu_result;
    endcase
  end

  // An unconditional write outranks a taken branch; a taken branch ignores pcsrc.
  assign w_pc_write         = pc_we | w_branch_taken;
  assign w_pc_wdata         = pc_we ? w_npc : r_alu_out;
  assign w_wdata_misaligned = (w_pc_wdata[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (w_pc_write) begin
      if (w_wdata_misaligned) begin
        r_misalign <= 1'b1;
      end else begin
        r_pc <= w_pc_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr   <= 32'h0000_0000;
      r_retired <= '0;
    end else if (ir_we) begin
      r_instr   <= mem_rdata;
      r_retired <= r_retired + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_out <= 32'h0000_0000;
    end else begin
      r_alu_out <= alu_result;
    end
  end

  assign pc           = r_pc;
  assign instruction  = r_instr;
  assign alu_out      = r_alu_out;
  assign link_addr    = r_pc;
  assign branch_taken = w_branch_taken;
  assign misalign_err = r_misalign;
  assign retired      = r_retired;

endmodule
